// File: rtl/ov5640_pkg.sv
// Shared types for the OV5640 capture controller: FSM encoding and lock default.
package ov5640_pkg;

  // Bit 1 = session gate (capture_on), bit 2 = store enable, so both outputs are raw state bits.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOCK = 3'b001,
    ST_SKIP = 3'b010,
    ST_CAPT = 3'b110
  } cap_state_e;

  localparam int          LOCK_FRAMES_DEF = 2;
  localparam logic [15:0] CNT_MAX         = 16'hFFFF;

endpackage

// File: rtl/ov5640_geom_meas.sv
// Sensor sync resampling, edge detection, line/frame geometry measurement and lock tracking.
module ov5640_geom_meas
  import ov5640_pkg::*;
#(
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        CCD_PCLK,
  input  logic        CCD_RSTN,
  input  logic        CCD_VSYNC,
  input  logic        CCD_HSYNC,
  input  logic [15:0] expect_width,
  input  logic [15:0] expect_height,
  output logic        vs_neg,
  output logic        frame_good,
  output logic        frame_valid
);

  localparam int LW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

  logic          vs_d1_q, vs_d2_q, hs_d1_q, hs_d2_q;
  logic          vs_d1_d, vs_d2_d, hs_d1_d, hs_d2_d;
  logic [15:0]   hcount_q, hcount_d, vcount_q, vcount_d;
  logic          line_bad_q, line_bad_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          hs_neg;

  assign vs_neg      = vs_d2_q & ~vs_d1_q;
  assign hs_neg      = hs_d2_q & ~hs_d1_q;
  assign frame_good  = ~line_bad_q && (vcount_q == expect_height);
  assign frame_valid = (lock_cnt_q == LOCK_MAX);

  always_comb begin
    vs_d1_d    = CCD_VSYNC;
    vs_d2_d    = vs_d1_q;
    hs_d1_d    = CCD_HSYNC;
    hs_d2_d    = hs_d1_q;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    line_bad_d = line_bad_q;
    lock_cnt_d = lock_cnt_q;

    if (vs_neg || hs_neg)                     hcount_d = '0;
    else if (hs_d1_q && hcount_q != CNT_MAX)  hcount_d = hcount_q + 16'd1;

    if (vs_neg)                               vcount_d = '0;
    else if (hs_neg && vcount_q != CNT_MAX)   vcount_d = vcount_q + 16'd1;

    if (vs_neg)                                       line_bad_d = 1'b0;
    else if (hs_neg && hcount_q != expect_width)      line_bad_d = 1'b1;

    // Any bad frame drops lock completely; good frames climb back one at a time.
    if (vs_neg) begin
      if (!frame_good)               lock_cnt_d = '0;
      else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN) begin
    if (!CCD_RSTN) begin
      vs_d1_q    <= 1'b0;
      vs_d2_q    <= 1'b0;
      hs_d1_q    <= 1'b0;
      hs_d2_q    <= 1'b0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      line_bad_q <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      vs_d1_q    <= vs_d1_d;
      vs_d2_q    <= vs_d2_d;
      hs_d1_q    <= hs_d1_d;
      hs_d2_q    <= hs_d2_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      line_bad_q <= line_bad_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/ov5640_capture_ctrl.sv
// OV5640 capture session controller: waits for geometry lock, then gates whole frames to the store path.
module ov5640_capture_ctrl
  import ov5640_pkg::*;
#(
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        CCD_PCLK,
  input  logic        CCD_RSTN,
  input  logic        CCD_VSYNC,
  input  logic        CCD_HSYNC,
  input  logic [15:0] expect_width,
  input  logic [15:0] expect_height,
  input  logic        start_req,
  input  logic        stop_req,
  input  logic [3:0]  frame_skip,
  input  logic [15:0] frame_limit,
  output logic        capture_on,
  output logic        frame_store_en,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        geom_err,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  logic vs_neg, frame_good;

  ov5640_geom_meas #(.LOCK_FRAMES(LOCK_FRAMES)) u_geom (
    .CCD_PCLK      (CCD_PCLK),
    .CCD_RSTN      (CCD_RSTN),
    .CCD_VSYNC     (CCD_VSYNC),
    .CCD_HSYNC     (CCD_HSYNC),
    .expect_width  (expect_width),
    .expect_height (expect_height),
    .vs_neg        (vs_neg),
    .frame_good    (frame_good),
    .frame_valid   (frame_valid)
  );

  cap_state_e  state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d, cnt_inc;
  logic [3:0]  skip_cnt_q, skip_cnt_d;
  logic        stop_pend_q, stop_pend_d;
  logic        frame_done_q, frame_done_d, geom_err_q, geom_err_d;

  assign cnt_inc = frame_cnt_q + 16'd1;

  always_ff @(posedge CCD_PCLK or negedge CCD_RSTN) begin
    if (!CCD_RSTN) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      skip_cnt_q   <= '0;
      stop_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      geom_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      stop_pend_q  <= stop_pend_d;
      frame_done_q <= frame_done_d;
      geom_err_q   <= geom_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    skip_cnt_d   = skip_cnt_q;
    stop_pend_d  = stop_pend_q;
    frame_done_d = 1'b0;
    geom_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_req && !stop_req) begin
        frame_cnt_d = '0;
        stop_pend_d = 1'b0;
        state_d     = ST_LOCK;
      end
      // frame_valid is the pre-edge value, so the frame starting now is already known-good geometry.
      ST_LOCK: begin
        if (stop_req)                      state_d = ST_IDLE;
        else if (vs_neg && frame_valid)    state_d = ST_CAPT;
      end
      ST_CAPT: begin
        if (stop_req) stop_pend_d = 1'b1;
        if (vs_neg) begin
          if (!frame_good) begin
            geom_err_d = 1'b1;
            state_d    = ST_LOCK;
          end else begin
            frame_done_d = 1'b1;
            frame_cnt_d  = cnt_inc;
            if (stop_pend_d || (frame_limit != 16'd0 && cnt_inc == frame_limit)) state_d = ST_IDLE;
            else if (frame_skip != 4'd0) begin
              skip_cnt_d = frame_skip;
              state_d    = ST_SKIP;
            end
          end
        end
      end
      ST_SKIP: begin
        if (stop_req) state_d = ST_IDLE;
        else if (vs_neg) begin
          if (skip_cnt_q == 4'd1) state_d    = ST_CAPT;
          else                    skip_cnt_d = skip_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture_on     = state_q[1];
    frame_store_en = state_q[2];
    busy           = (state_q != ST_IDLE);
    frame_done     = frame_done_q;
    geom_err       = geom_err_q;
    frame_cnt      = frame_cnt_q;
  end

endmodule

// File: tb/tb_ov5640_capture_ctrl.sv
// Directed bench: small 8x4 frames drive lock, capture, skip/limit, stop, geometry error and reset cases.
module tb_ov5640_capture_ctrl;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vsync, hsync;
  logic [15:0] exp_w, exp_h;
  logic        start_req, stop_req;
  logic [3:0]  frame_skip;
  logic [15:0] frame_limit;
  logic        capture_on, frame_store_en, frame_valid, frame_done, geom_err, busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  ov5640_capture_ctrl dut (
    .CCD_PCLK       (clk),
    .CCD_RSTN       (rstn),
    .CCD_VSYNC      (vsync),
    .CCD_HSYNC      (hsync),
    .expect_width   (exp_w),
    .expect_height  (exp_h),
    .start_req      (start_req),
    .stop_req       (stop_req),
    .frame_skip     (frame_skip),
    .frame_limit    (frame_limit),
    .capture_on     (capture_on),
    .frame_store_en (frame_store_en),
    .frame_valid    (frame_valid),
    .frame_done     (frame_done),
    .geom_err       (geom_err),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (geom_err)   err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_req = 1'b1; tick(); start_req = 1'b0; tick();
  endtask

  // Blanking, VSYNC fall (closes the previous frame), then H lines; optional short line / stop pulse.
  task automatic frame(input int bad_line, input int stop_line);
    vsync = 1'b1; repeat (4) tick();
    vsync = 1'b0; repeat (2) tick();
    for (int l = 0; l < H; l++) begin
      int w;
      w = (l == bad_line) ? W - 1 : W;
      hsync = 1'b1;
      for (int c = 0; c < w; c++) begin
        stop_req = (l == stop_line && c == 2);
        tick();
      end
      stop_req = 1'b0;
      hsync    = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic chk_state(input string tag, input logic on, input logic st, input logic bsy);
    chk({tag, "_on"},   capture_on,     on);
    chk({tag, "_st"},   frame_store_en, st);
    chk({tag, "_busy"}, busy,           bsy);
  endtask

  initial begin
    rstn = 1'b0; vsync = 1'b0; hsync = 1'b0;
    exp_w = 16'(W); exp_h = 16'(H);
    start_req = 1'b0; stop_req = 1'b0;
    frame_skip = 4'd0; frame_limit = 16'd0;
    repeat (3) tick();
    chk_state("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_fv", frame_valid, 0);
    rstn = 1'b1; tick();

    // Simultaneous start/stop in IDLE is ignored
    start_req = 1'b1; stop_req = 1'b1; tick();
    start_req = 1'b0; stop_req = 1'b0; tick();
    chk("startstop_busy", busy, 0);

    pulse_start();
    chk_state("lock0", 1'b0, 1'b0, 1'b1);

    frame(-1, -1);                       // first VSYNC fall: nothing measured, bad
    chk("f1_fv", frame_valid, 0);
    frame(-1, -1);                       // lock 1
    chk("f2_fv", frame_valid, 0);
    frame(-1, -1);                       // lock 2, still LOCK
    chk("f3_fv", frame_valid, 1);
    chk_state("f3", 1'b0, 1'b0, 1'b1);
    frame(-1, -1);                       // enter CAPT
    chk_state("f4", 1'b1, 1'b1, 1'b1);
    chk("f4_done", done_seen, 0);
    frame(-1, -1);
    chk("f5_cnt", frame_cnt, 1);
    chk("f5_done", done_seen, 1);
    frame(1, -1);                        // captured frame carries a short line
    chk("f6_cnt", frame_cnt, 2);
    frame(-1, -1);                       // bad frame judged here
    chk("gerr_cnt", err_seen, 1);
    chk("gerr_fcnt", frame_cnt, 2);
    chk("gerr_fv", frame_valid, 0);
    chk_state("gerr", 1'b0, 1'b0, 1'b1);
    frame(-1, -1);
    frame(-1, -1);
    chk("relock_fv", frame_valid, 1);
    chk_state("relock", 1'b0, 1'b0, 1'b1);
    frame(-1, -1);
    chk_state("recapt", 1'b1, 1'b1, 1'b1);

    // Stop mid-line: current frame still completes and is counted
    frame(-1, 1);
    chk("stop_cnt", frame_cnt, 3);
    chk_state("stop_pend", 1'b1, 1'b1, 1'b1);
    frame(-1, -1);
    chk_state("stop_idle", 1'b0, 1'b0, 1'b0);
    chk("stop_fcnt", frame_cnt, 4);
    chk("stop_done", done_seen, 4);

    // Skip 2, limit 3
    frame_skip = 4'd2; frame_limit = 16'd3;
    pulse_start();
    chk("sk_cnt0", frame_cnt, 0);
    frame(-1, -1);
    chk_state("sk_capt", 1'b1, 1'b1, 1'b1);
    frame(-1, -1);
    chk("sk_cnt1", frame_cnt, 1);
    chk_state("sk_skip1", 1'b1, 1'b0, 1'b1);
    frame(-1, -1);
    chk_state("sk_skip2", 1'b1, 1'b0, 1'b1);
    frame(-1, -1);
    chk_state("sk_capt2", 1'b1, 1'b1, 1'b1);
    frame(-1, -1);
    chk("sk_cnt2", frame_cnt, 2);
    chk_state("sk_skip3", 1'b1, 1'b0, 1'b1);
    frame(-1, -1);
    frame(-1, -1);
    chk_state("sk_capt3", 1'b1, 1'b1, 1'b1);
    frame(-1, -1);
    chk("sk_cnt3", frame_cnt, 3);
    chk_state("sk_end", 1'b0, 1'b0, 1'b0);
    chk("sk_done", done_seen, 7);

    // Reset during CAPT
    frame_skip = 4'd0; frame_limit = 16'd0;
    pulse_start();
    frame(-1, -1);
    chk_state("pre_rst", 1'b1, 1'b1, 1'b1);
    rstn = 1'b0; #1;
    chk_state("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst_fv", frame_valid, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    tick(); tick(); rstn = 1'b1;
    frame(-1, -1);
    frame(-1, -1);
    frame(-1, -1);
    frame(-1, -1);
    chk_state("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst_fv", frame_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
